// File: rtl/aq_gemac_arp_responder_if.sv
// MAC buffer bus seen by the ARP responder: RX buffer read side and
// TX buffer write side. master = responder, slave = MAC buffers.
interface aq_gemac_arp_responder_if;
  logic        RX_BUFF_RE;
  logic [31:0] RX_BUFF_DATA;
  logic        RX_BUFF_EMPTY;
  logic        RX_BUFF_VALID;
  logic [15:0] RX_BUFF_LENGTH;
  logic [15:0] RX_BUFF_STATUS;
  logic        TX_BUFF_WE;
  logic        TX_BUFF_START;
  logic        TX_BUFF_END;
  logic [31:0] TX_BUFF_DATA;
  logic        TX_BUFF_READY;
  logic        TX_BUFF_FULL;

  modport master (
    output RX_BUFF_RE,
    input  RX_BUFF_DATA, RX_BUFF_EMPTY, RX_BUFF_VALID, RX_BUFF_LENGTH, RX_BUFF_STATUS,
    output TX_BUFF_WE, TX_BUFF_START, TX_BUFF_END, TX_BUFF_DATA,
    input  TX_BUFF_READY, TX_BUFF_FULL
  );

  modport slave (
    input  RX_BUFF_RE,
    output RX_BUFF_DATA, RX_BUFF_EMPTY, RX_BUFF_VALID, RX_BUFF_LENGTH, RX_BUFF_STATUS,
    input  TX_BUFF_WE, TX_BUFF_START, TX_BUFF_END, TX_BUFF_DATA,
    output TX_BUFF_READY, TX_BUFF_FULL
  );
endinterface

// File: rtl/aq_gemac_arp_responder.sv
// Hardware ARP responder: reads each RX frame, answers ARP requests for the
// local IP with a 60-byte reply in the TX buffer, drains everything else.
module aq_gemac_arp_responder (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic                            ENABLE,
  input  logic [47:0]                     MAC_ADDRESS,
  input  logic [31:0]                     IP_ADDRESS,
  aq_gemac_arp_responder_if.master        bus,
  output logic [15:0]                     REPLY_COUNT,
  output logic [15:0]                     DROP_COUNT
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CHECK   = 3'd2,
    WAIT_TX = 3'd3,
    SEND    = 3'd4,
    GAP     = 3'd5
  } state_t;

  state_t      state;
  logic [15:0] frame_len;
  logic [15:0] frame_status;
  logic [16:0] words;      // RE cycles owed for the current frame
  logic [16:0] re_cnt;     // RE cycles issued so far (1-based)
  logic [16:0] rd_idx;     // index of the next word to arrive on VALID
  logic [3:0]  tx_idx;     // reply word being offered to the TX buffer

  // Captured request fields; byte 0 of each field is in bits [7:0]
  logic [31:0] type_htype;
  logic [31:0] ptype_len;
  logic [15:0] oper;
  logic [47:0] sha;
  logic [31:0] spa;
  logic [15:0] tpa_lo;
  logic [15:0] tpa_hi;

  logic [16:0] len_sum;
  logic [16:0] words_next;
  logic        match;
  logic [31:0] reply_word;

  // Word count of the head frame, never less than one word
  always_comb begin
    len_sum = {1'b0, bus.RX_BUFF_LENGTH} + 17'd3;
    if ((len_sum >> 2) == 17'd0) begin
      words_next = 17'd1;
    end else begin
      words_next = len_sum >> 2;
    end
  end

  // Request qualification evaluated in CHECK
  always_comb begin
    match = (frame_status == 16'd0) &&
            (frame_len >= 16'd42) &&
            ENABLE &&
            (type_htype == 32'h0100_0608) &&
            (ptype_len == 32'h0406_0008) &&
            (oper == 16'h0100) &&
            ({tpa_hi, tpa_lo} == IP_ADDRESS);
  end

  // Reply word selected by tx_idx; words 11..14 are padding
  always_comb begin
    case (tx_idx)
      4'd0:    reply_word = sha[31:0];
      4'd1:    reply_word = {MAC_ADDRESS[15:0], sha[47:32]};
      4'd2:    reply_word = MAC_ADDRESS[47:16];
      4'd3:    reply_word = 32'h0100_0608;
      4'd4:    reply_word = 32'h0406_0008;
      4'd5:    reply_word = {MAC_ADDRESS[15:0], 16'h0200};
      4'd6:    reply_word = MAC_ADDRESS[47:16];
      4'd7:    reply_word = IP_ADDRESS;
      4'd8:    reply_word = sha[31:0];
      4'd9:    reply_word = {spa[15:0], sha[47:32]};
      4'd10:   reply_word = {16'h0000, spa[31:16]};
      default: reply_word = 32'h0000_0000;
    endcase
  end

  // TX strobes: WE follows FULL combinationally so a stalled word is held
  always_comb begin
    if (state == SEND) begin
      bus.TX_BUFF_WE    = ~bus.TX_BUFF_FULL;
      bus.TX_BUFF_START = (tx_idx == 4'd0);
      bus.TX_BUFF_END   = (tx_idx == 4'd14);
      bus.TX_BUFF_DATA  = reply_word;
    end else begin
      bus.TX_BUFF_WE    = 1'b0;
      bus.TX_BUFF_START = 1'b0;
      bus.TX_BUFF_END   = 1'b0;
      bus.TX_BUFF_DATA  = 32'h0000_0000;
    end
  end

  // Frame sequencer: read, qualify, reply or drop, one frame at a time
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state          <= IDLE;
      frame_len      <= 16'd0;
      frame_status   <= 16'd0;
      words          <= 17'd0;
      re_cnt         <= 17'd0;
      rd_idx         <= 17'd0;
      tx_idx         <= 4'd0;
      type_htype     <= 32'd0;
      ptype_len      <= 32'd0;
      oper           <= 16'd0;
      sha            <= 48'd0;
      spa            <= 32'd0;
      tpa_lo         <= 16'd0;
      tpa_hi         <= 16'd0;
      bus.RX_BUFF_RE <= 1'b0;
      REPLY_COUNT    <= 16'd0;
      DROP_COUNT     <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.RX_BUFF_EMPTY) begin
            frame_len      <= bus.RX_BUFF_LENGTH;
            frame_status   <= bus.RX_BUFF_STATUS;
            words          <= words_next;
            re_cnt         <= 17'd1;
            rd_idx         <= 17'd0;
            bus.RX_BUFF_RE <= 1'b1;
            state          <= READ;
          end
        end
        READ: begin
          if (bus.RX_BUFF_RE) begin
            if (re_cnt == words) begin
              bus.RX_BUFF_RE <= 1'b0;
            end else begin
              re_cnt <= re_cnt + 17'd1;
            end
          end
          if (bus.RX_BUFF_VALID) begin
            case (rd_idx)
              17'd3:   type_htype <= bus.RX_BUFF_DATA;
              17'd4:   ptype_len  <= bus.RX_BUFF_DATA;
              17'd5: begin
                oper       <= bus.RX_BUFF_DATA[15:0];
                sha[15:0]  <= bus.RX_BUFF_DATA[31:16];
              end
              17'd6:   sha[47:16] <= bus.RX_BUFF_DATA;
              17'd7:   spa        <= bus.RX_BUFF_DATA;
              17'd9:   tpa_lo     <= bus.RX_BUFF_DATA[31:16];
              17'd10:  tpa_hi     <= bus.RX_BUFF_DATA[15:0];
              default: begin end
            endcase
            rd_idx <= rd_idx + 17'd1;
            if (rd_idx == words - 17'd1) begin
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (match) begin
            state <= WAIT_TX;
          end else begin
            DROP_COUNT <= DROP_COUNT + 16'd1;
            state      <= GAP;
          end
        end
        WAIT_TX: begin
          if (bus.TX_BUFF_READY) begin
            tx_idx <= 4'd0;
            state  <= SEND;
          end
        end
        SEND: begin
          if (!bus.TX_BUFF_FULL) begin
            if (tx_idx == 4'd14) begin
              tx_idx      <= 4'd0;
              REPLY_COUNT <= REPLY_COUNT + 16'd1;
              state       <= GAP;
            end else begin
              tx_idx <= tx_idx + 4'd1;
            end
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/aq_gemac_arp_responder.md
# aq_gemac_arp_responder

Hardware ARP responder on the system-clock side of the MAC. It consumes received frames from the MAC RX buffer interface and recognises ARP requests whose target protocol address equals the local IP address. For each such request it writes a 60-byte ARP reply into the MAC TX buffer interface; every other frame is drained and dropped. It is the responder to a remote ARP initiator and the writer for the TX buffer the MAC reads.

## Interface
Parameters: none.

Ports:
- CLK  in  1  system clock; all logic on rising edge
- RST_N  in  1  reset, asynchronous assert, active-low
- ENABLE  in  1  1 = reply to matching requests; 0 = drain and drop all frames
- MAC_ADDRESS  in  48  local MAC; [7:0] is first byte on the wire
- IP_ADDRESS  in  32  local IPv4; [7:0] is first byte on the wire (32'h0101A8C0 = 192.168.1.1)
- RX_BUFF_RE  out  1  read strobe, one 32-bit word per cycle high
- RX_BUFF_DATA  in  32  read word; byte n of a word in bits [8n+7:8n]
- RX_BUFF_EMPTY  in  1  0 = at least one complete frame queued
- RX_BUFF_VALID  in  1  RX_BUFF_DATA valid; exactly one cycle after each RE
- RX_BUFF_LENGTH  in  16  byte length of head frame, DA through payload, no FCS; valid while EMPTY=0
- RX_BUFF_STATUS  in  16  head frame status; any nonzero bit = errored frame
- TX_BUFF_WE  out  1  write strobe
- TX_BUFF_START  out  1  marks first word of frame, with WE
- TX_BUFF_END  out  1  marks last word of frame, with WE
- TX_BUFF_DATA  out  32  write word, same byte order as RX
- TX_BUFF_READY  in  1  1 = buffer can accept a new frame
- TX_BUFF_FULL  in  1  1 = no word may be written this cycle
- REPLY_COUNT  out  16  replies sent, wraps at 65535
- DROP_COUNT  out  16  frames dropped, wraps at 65535

## Operation
- States: IDLE, READ, CHECK, WAIT_TX, SEND, GAP.
- IDLE: when RX_BUFF_EMPTY=0, latch LENGTH and STATUS, compute words = max(1, (LENGTH+3)>>2) (17-bit sum, no overflow), go to READ.
- READ: assert RE for exactly `words` consecutive cycles. Capture the word at each VALID by word index: w3 bytes 12–15 (type, htype), w4 (ptype, hlen, plen), w5 (oper, SHA[0:1]), w6 (SHA[2:5]), w7 (SPA), w8 (THA), w9/w10 (TPA bytes 38–41). After the last VALID, go to CHECK.
- CHECK (1 cycle): match requires all of: STATUS=0, LENGTH>=42, ENABLE=1, type 08 06, htype 00 01, ptype 08 00, hlen 06, plen 04, oper 00 01, TPA=IP_ADDRESS. Match goes to WAIT_TX; otherwise DROP_COUNT+1 and go to GAP.
- WAIT_TX: wait for TX_BUFF_READY=1, then go to SEND.
- SEND: 15 words, 60 bytes. Bytes 0–5 DA=req SHA; 6–11 SA=MAC; 12–13 08 06; 14–15 00 01; 16–17 08 00; 18 06; 19 04; 20–21 00 02; 22–27 MAC; 28–31 IP; 32–37 req SHA; 38–41 req SPA; 42–59 zero.
- SEND write rule: WE=1 only in cycles where TX_BUFF_FULL=0, gated combinationally; the word index advances only on WE. START is set with word 0 and END with word 14. After END is written, REPLY_COUNT+1, go to GAP.
- GAP (1 cycle): lets EMPTY/LENGTH update for the next frame, then go to IDLE.
- ENABLE and the address inputs are sampled in CHECK and while composing the reply. A change during SEND is not guaranteed to be consistent; the system holds them static.

## Timing
- Reset values: all outputs 0, counters 0, state IDLE. Reset mid-frame abandons it: no END is issued and the RX frame is left partially read. The system resets the MAC buffers together with this block.
- From EMPTY=0 sampled in IDLE, the first RE comes on the next cycle.
- CHECK is the cycle after the last VALID. With READY=1 and FULL=0 throughout, TX_BUFF_START/WE come 2 cycles after CHECK (WAIT_TX 1 cycle, then SEND), and 15 consecutive WE cycles follow.
- FULL stalls: DATA, START, and END hold on the current word until it is written. No word is skipped or duplicated.
- Throughput: one frame per words+4 cycles plus stalls. The block never reads RX while in SEND.

## Test plan
- Valid request (LENGTH=60, TPA C0 A8 01 01, SHA 02 11 22 33 44 55, SPA C0 A8 01 0A) -> 15 RE, then 15 WE with START on word 0 and END on word 14. Word 0 = 32'h33221102, word 1 = 32'h00005544, word 5 = 32'h00000200. REPLY_COUNT=1.
- Same request with TPA C0 A8 01 02 -> 15 RE, no WE, DROP_COUNT=1.
- Requests with STATUS=16'h0001, LENGTH=41, oper 00 02, or ENABLE=0 -> each drained, no WE, DROP_COUNT increments by one per frame.
- Valid request with READY low for 10 cycles, then FULL toggling every other cycle -> first WE 1 cycle after READY rises; exactly 15 WE; words in order; DATA held while FULL=1.
- Two valid requests back-to-back plus one IPv4 frame (LENGTH=1514, 379 RE) -> two correct replies in order; the IPv4 frame fully drained; REPLY_COUNT=2, DROP_COUNT=1.
- Assert RST_N low during SEND word 7 -> all outputs 0 asynchronously; after release, the next valid request yields a complete reply.
